// File: rtl/dm_pkg.sv
// Shared definitions for the dm_responder data-memory slave.
package dm_pkg;

    // Responder FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Default geometry: 1024 x 32-bit words (4 KiB)
    localparam int DM_DEPTH_LOG2_DEF  = 10;
    // Default number of wait states between accept and response
    localparam int DM_WAIT_CYCLES_DEF = 1;
    // Wait counter width; holds wait-state counts 0..15
    localparam int DM_CNT_W           = 4;

    // Byte-lane merge: lanes with be[i]=1 take the new data, others keep the old word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word-organised storage: combinational read, synchronous byte-enable write,
// synchronous clear of every word while reset is high.
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = DM_DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    input  logic [3:0]            be,
    output logic [31:0]           rdata
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [WORDS];
    logic [31:0] word_d;

    assign rdata = mem_q[idx];

    // Merged word to be written: untouched lanes keep their current contents
    always_comb begin
        word_d = be_merge(mem_q[idx], wdata, be);
    end

    // Storage update: reset clears all words and wins over any write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (wr_en) begin
            mem_q[idx] <= word_d;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Single-port data-memory responder: accepts a load/store request, inserts
// WAIT_CYCLES wait states, then answers with a one-cycle ready strobe.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2  = DM_DEPTH_LOG2_DEF,
    parameter int WAIT_CYCLES = DM_WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam logic [DM_CNT_W-1:0] WAIT_INIT = DM_CNT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [DM_CNT_W-1:0] cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;

    logic [31:0]           addr_hi;
    logic                  addr_err;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  resp_live;
    logic                  mem_wr_en;
    logic [31:0]           mem_rdata;

    // Next-state, wait counter and request latch capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (WAIT_CYCLES == 0) begin
                        cnt_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Leaving when the count is at 1 gives exactly WAIT_CYCLES wait states
                if (cnt_q <= 1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latches; only meaningful after an accept, so they carry no reset
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // Address decode: misaligned or beyond the array is an error
    always_comb begin
        addr_hi  = addr_q >> (DEPTH_LOG2 + 2);
        addr_err = (addr_q[1:0] != 2'b00) || (addr_hi != 32'h0);
        word_idx = addr_q[DEPTH_LOG2+1:2];
    end

    // Response muxing; reset in the RESP cycle suppresses both the strobe and the store
    always_comb begin
        resp_live = (state_q == ST_RESP) && !reset;
        mem_wr_en = resp_live && we_q && !addr_err;
        ready     = 1'b0;
        err       = 1'b0;
        rdata     = 32'h0000_0000;
        if (resp_live) begin
            ready = 1'b1;
            err   = addr_err;
            rdata = addr_err ? 32'h0000_0000 : mem_rdata;
        end
    end

    dm_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .reset(reset),
        .wr_en(mem_wr_en),
        .idx  (word_idx),
        .wdata(wdata_q),
        .be   (be_q),
        .rdata(mem_rdata)
    );

endmodule
